// File: rtl/iomem_pkg.sv
// iomem_pkg -- definitions shared by the iomem program-RAM slice.
//
// Contents:
//   PROG_REGION_DEF / CTRL_REGION_DEF : default iomem_addr[31:24] selectors
//   CTRL_RUN_BIT                      : bit position of the run enable in ctrl
//   bus_state_t                       : bus handshake FSM state encoding
//   ctrl_word()                       : builds the ctrl register read value
package iomem_pkg;

  localparam logic [7:0] PROG_REGION_DEF = 8'h60;
  localparam logic [7:0] CTRL_REGION_DEF = 8'h62;
  localparam int         CTRL_RUN_BIT    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_t;

  // Only the run bit is implemented; every other ctrl bit reads as zero.
  function automatic logic [31:0] ctrl_word(input logic run_bit);
    ctrl_word = 32'(run_bit) << CTRL_RUN_BIT;
  endfunction

endpackage

// File: rtl/dpram.sv
// dpram -- program RAM with one read/write bus port and one read-only
// engine port. Both read ports are registered (one-cycle latency) and return
// the pre-write word when a write hits the same address on the same edge.
//
// Ports:
//   ck        : clock
//   rst       : asynchronous active-high reset of the read registers only;
//               the array itself is never cleared
//   bus_addr  : bus-side word address
//   bus_we    : per-byte write enables (bit n -> bits 8n+7:8n)
//   bus_wdata : bus-side write data
//   bus_rdata : bus-side registered read data
//   eng_addr  : engine-side word address
//   eng_data  : engine-side registered read data
module dpram #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 32
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  bus_addr,
  input  logic [DATA_W/8-1:0]   bus_we,
  input  logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W-1:0]     bus_rdata,
  input  logic [ADDR_BITS-1:0]  eng_addr,
  output logic [DATA_W-1:0]     eng_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge ck) begin
    for (int n = 0; n < DATA_W/8; n++) begin
      if (bus_we[n]) begin
        mem[bus_addr][8*n +: 8] <= bus_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      bus_rdata <= '0;
      eng_data  <= '0;
    end else begin
      bus_rdata <= mem[bus_addr];
      eng_data  <= mem[eng_addr];
    end
  end

endmodule

// File: rtl/iomem_prog_ram.sv
// iomem_prog_ram -- program RAM and run-control register behind a PicoRV32
// style iomem port, with a second read-only port for the engine that
// executes the program.
//
// Every selected access takes IDLE -> BUSY -> ACK -> IDLE, so iomem_ready
// pulses two cycles after the request is first sampled. The request is
// captured while IDLE; bus changes afterwards are ignored. Program RAM writes
// are dropped while run=1 (the handshake still completes).
//
// Build option: define PROG_RAM_READBACK_EN to return program RAM contents on
// program-region reads; otherwise those reads acknowledge with zero data.
//
// Ports:
//   ck          : clock, all state on posedge
//   rst         : asynchronous active-high reset
//   iomem_valid : initiator request
//   iomem_ready : one-cycle completion pulse
//   iomem_wstrb : byte-lane write enables, 0 = read
//   iomem_addr  : byte address; [31:24] selects the region
//   iomem_wdata : write data
//   iomem_rdata : read data, zero whenever iomem_ready=0
//   eng_addr    : engine program fetch address (word)
//   eng_data    : fetched opcode, one-cycle latency
//   run         : ctrl bit 0, engine run enable
module iomem_prog_ram
  import iomem_pkg::*;
#(
  parameter int         ADDR_BITS   = 8,
  parameter logic [7:0] PROG_REGION = PROG_REGION_DEF,
  parameter logic [7:0] CTRL_REGION = CTRL_REGION_DEF
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  input  logic [ADDR_BITS-1:0]  eng_addr,
  output logic [31:0]           eng_data,
  output logic                  run
);

  bus_state_t state, state_nxt;

  logic                  hit;
  logic                  sel_prog_q;
  logic [ADDR_BITS-1:0]  word_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;
  logic                  is_write;
  logic [3:0]            ram_we;
  logic [31:0]           ram_bus_rdata;

  assign hit = iomem_valid &&
               ((iomem_addr[31:24] == PROG_REGION) || (iomem_addr[31:24] == CTRL_REGION));

  // Byte offset and in-region bits above the RAM index are don't-care
  // (the latter alias onto the RAM).
  logic addr_unused;
  assign addr_unused = ^iomem_addr[23:0];

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hit) state_nxt = ST_BUSY;
      ST_BUSY: state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture: tracks the bus every IDLE cycle, frozen from the edge
  // that accepts the request until the FSM is back in IDLE.
  always_ff @(posedge ck) begin
    if (state == ST_IDLE) begin
      sel_prog_q <= (iomem_addr[31:24] == PROG_REGION);
      word_q     <= iomem_addr[ADDR_BITS+1:2];
      wstrb_q    <= iomem_wstrb;
      wdata_q    <= iomem_wdata;
    end
  end

  assign is_write = |wstrb_q;

  // The RAM write lands on the BUSY -> ACK edge. An asynchronous reset during
  // BUSY drops the FSM to IDLE before that edge, so nothing is written.
  assign ram_we = (state == ST_BUSY && sel_prog_q && !run) ? wstrb_q : 4'b0000;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
    end else if (state == ST_BUSY && !sel_prog_q && wstrb_q[CTRL_RUN_BIT/8]) begin
      run <= wdata_q[CTRL_RUN_BIT];
    end
  end

  dpram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (32)
  ) u_dpram (
    .ck        (ck),
    .rst       (rst),
    .bus_addr  (word_q),
    .bus_we    (ram_we),
    .bus_wdata (wdata_q),
    .bus_rdata (ram_bus_rdata),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data)
  );

  assign iomem_ready = (state == ST_ACK);

`ifndef PROG_RAM_READBACK_EN
  // Bus-side RAM data is only consumed when readback is built in.
  logic rdbk_unused;
  assign rdbk_unused = ^ram_bus_rdata;
`endif

  // The bus read register sampled word_q on the BUSY -> ACK edge, so it holds
  // the addressed word throughout ACK.
  always_comb begin
    iomem_rdata = '0;
    if (state == ST_ACK && !is_write) begin
      if (sel_prog_q) begin
`ifdef PROG_RAM_READBACK_EN
        iomem_rdata = ram_bus_rdata;
`else
        iomem_rdata = '0;
`endif
      end else begin
        iomem_rdata = ctrl_word(run);
      end
    end
  end

endmodule

// File: tb/tb_iomem_prog_ram.sv
module tb_iomem_prog_ram;

  localparam int AB    = 8;
  localparam int DEPTH = 1 << AB;
`ifdef PROG_RAM_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic          ck = 1'b0;
  logic          rst;
  logic          iomem_valid;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb;
  logic [31:0]   iomem_addr;
  logic [31:0]   iomem_wdata;
  logic [31:0]   iomem_rdata;
  logic [AB-1:0] eng_addr;
  logic [31:0]   eng_data;
  logic          run;

  always #5 ck = ~ck;

  iomem_prog_ram #(.ADDR_BITS(AB)) dut (
    .ck          (ck),
    .rst         (rst),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .eng_addr    (eng_addr),
    .eng_data    (eng_data),
    .run         (run)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain word array plus the run flag.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_run;

  function automatic void model_write(input logic [31:0] a, input logic [3:0] s,
                                      input logic [31:0] d);
    int idx;
    idx = int'(a[AB+1:2]);
    if (a[31:24] == 8'h60) begin
      if (!ref_run) begin
        for (int n = 0; n < 4; n++) begin
          if (s[n]) ref_mem[idx][8*n +: 8] = d[8*n +: 8];
        end
      end
    end else if (a[31:24] == 8'h62) begin
      if (s[0]) ref_run = d[0];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:24] == 8'h60) return READBACK ? ref_mem[int'(a[AB+1:2])] : 32'h0;
    return {31'b0, ref_run};
  endfunction

  // Results of the most recent bus transfer.
  int          last_lat;
  logic [31:0] last_rdata;
  logic [31:0] last_eng_ack;
  logic        last_ready_after;
  logic [31:0] last_rdata_after;
  bit          last_leak;

  // One bus transfer. After the first edge the bus is scrambled to show the
  // captured request is what executes. Valid drops as soon as ready is seen.
  task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 0;
    last_leak = 0;
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    while (!seen && cyc < 8) begin
      @(posedge ck); #1;
      cyc++;
      if (cyc == 1) begin
        iomem_addr  = $urandom();
        iomem_wstrb = 4'($urandom());
        iomem_wdata = $urandom();
      end
      if (iomem_ready) seen = 1;
      else if (iomem_rdata !== 32'h0) last_leak = 1;
    end
    last_lat     = seen ? cyc : -1;
    last_rdata   = iomem_rdata;
    last_eng_ack = eng_data;
    iomem_valid  = 1'b0;
    iomem_wstrb  = 4'h0;
    @(posedge ck); #1;
    last_ready_after = iomem_ready;
    last_rdata_after = iomem_rdata;
    if (seen) model_write(a, s, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    eng_addr    = '0;
    ref_run     = 0;
    repeat (3) @(posedge ck);
    #1;
    n_tests++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", iomem_ready); end
    n_tests++; if (iomem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", iomem_rdata); end
    n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run got %b exp 0", run); end
    n_tests++; if (eng_data !== 32'h0) begin n_fail++; $display("FAIL reset_eng_data got %h exp 0", eng_data); end
    rst = 1'b0;
    @(posedge ck); #1;
  endtask

  task automatic test_init_ram();
    int bad;
    bad = 0;
    for (int w = 0; w < DEPTH; w++) begin
      bus_xfer(32'h6000_0000 | (32'(w) << 2), 4'hF, $urandom());
      if (last_lat != 2 || last_ready_after !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL init_handshakes got %0d bad exp 0", bad); end
    for (int w = 0; w < DEPTH; w += 37) begin
      eng_addr = AB'(w);
      @(posedge ck); #1;
      n_tests++; if (eng_data !== ref_mem[w]) begin n_fail++; $display("FAIL init_word[%0d] got %h exp %h", w, eng_data, ref_mem[w]); end
    end
  endtask

  task automatic test_readback();
    logic [31:0] exp;
    bus_xfer(32'h6000_0000, 4'hF, 32'h8421_2000);
    n_tests++; if (last_lat != 2) begin n_fail++; $display("FAIL rb_write_latency got %0d exp 2", last_lat); end
    exp = READBACK ? 32'h8421_2000 : 32'h0;
    bus_xfer(32'h6000_0000, 4'h0, 32'h0);
    n_tests++; if (last_lat != 2) begin n_fail++; $display("FAIL rb_read_latency got %0d exp 2", last_lat); end
    n_tests++; if (last_rdata !== exp) begin n_fail++; $display("FAIL rb_rdata got %h exp %h", last_rdata, exp); end
    n_tests++; if (last_ready_after !== 1'b0) begin n_fail++; $display("FAIL rb_ready_pulse got %b exp 0", last_ready_after); end
    n_tests++; if (last_rdata_after !== 32'h0) begin n_fail++; $display("FAIL rb_rdata_after got %h exp 0", last_rdata_after); end
    n_tests++; if (last_leak !== 1'b0) begin n_fail++; $display("FAIL rb_rdata_leak got %b exp 0", last_leak); end
    eng_addr = '0;
    @(posedge ck); #1;
    n_tests++; if (eng_data !== 32'h8421_2000) begin n_fail++; $display("FAIL rb_eng_word0 got %h exp 84212000", eng_data); end
  endtask

  task automatic test_ctrl_run();
    logic [31:0] old;
    bus_xfer(32'h6200_0000, 4'hF, 32'h1);
    n_tests++; if (run !== 1'b1) begin n_fail++; $display("FAIL ctrl_run_set got %b exp 1", run); end
    old = ref_mem[1];
    bus_xfer(32'h6000_0004, 4'hF, 32'hfe00_0000);
    n_tests++; if (last_lat != 2) begin n_fail++; $display("FAIL ctrl_locked_latency got %0d exp 2", last_lat); end
    eng_addr = AB'(1);
    @(posedge ck); #1;
    n_tests++; if (eng_data !== old) begin n_fail++; $display("FAIL ctrl_locked_word got %h exp %h", eng_data, old); end
    bus_xfer(32'h6200_0000, 4'h0, 32'h0);
    n_tests++; if (last_rdata !== 32'h1) begin n_fail++; $display("FAIL ctrl_read_1 got %h exp 1", last_rdata); end
    bus_xfer(32'h6200_0000, 4'b1110, 32'h0);
    n_tests++; if (run !== 1'b1) begin n_fail++; $display("FAIL ctrl_lane0_off got %b exp 1", run); end
    bus_xfer(32'h6200_0000, 4'hF, 32'hffff_fffe);
    n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL ctrl_run_clear got %b exp 0", run); end
    bus_xfer(32'h6200_0000, 4'h0, 32'h0);
    n_tests++; if (last_rdata !== 32'h0) begin n_fail++; $display("FAIL ctrl_read_0 got %h exp 0", last_rdata); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] w;
    logic [3:0]  s;
    bus_xfer(32'h6000_0008, 4'hF, 32'hffff_ffff);
    bus_xfer(32'h6000_0008, 4'b0011, 32'h0000_abcd);
    eng_addr = AB'(2);
    @(posedge ck); #1;
    n_tests++; if (eng_data !== 32'hffff_abcd) begin n_fail++; $display("FAIL lanes_0011 got %h exp ffffabcd", eng_data); end
    for (int i = 0; i < 8; i++) begin
      w = 32'($urandom_range(0, DEPTH-1));
      s = 4'($urandom_range(1, 15));
      bus_xfer(32'h6000_0000 | (w << 2), s, $urandom());
      eng_addr = w[AB-1:0];
      @(posedge ck); #1;
      n_tests++; if (eng_data !== ref_mem[w]) begin n_fail++; $display("FAIL lanes_rand s=%b got %h exp %h", s, eng_data, ref_mem[w]); end
    end
  endtask

  task automatic test_unselected();
    int bad_rdy;
    int bad_dat;
    bad_rdy = 0;
    bad_dat = 0;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h6400_0000;
    iomem_wstrb = 4'hF;
    iomem_wdata = ~ref_mem[0];
    for (int c = 0; c < 10; c++) begin
      @(posedge ck); #1;
      if (iomem_ready !== 1'b0) bad_rdy++;
      if (iomem_rdata !== 32'h0) bad_dat++;
    end
    n_tests++; if (bad_rdy != 0) begin n_fail++; $display("FAIL unsel_ready got %0d pulses exp 0", bad_rdy); end
    n_tests++; if (bad_dat != 0) begin n_fail++; $display("FAIL unsel_rdata got %0d nonzero exp 0", bad_dat); end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    eng_addr = '0;
    @(posedge ck); #1;
    n_tests++; if (eng_data !== ref_mem[0]) begin n_fail++; $display("FAIL unsel_word0 got %h exp %h", eng_data, ref_mem[0]); end
  endtask

  task automatic test_reset_mid_busy();
    int          w;
    int          pulses;
    logic [31:0] old;
    bus_xfer(32'h6200_0000, 4'hF, 32'h0);
    @(posedge ck); #1;
    w = $urandom_range(0, DEPTH-1);
    old = ref_mem[w];
    iomem_valid = 1'b1;
    iomem_addr  = 32'h6000_0000 | (32'(w) << 2);
    iomem_wstrb = 4'hF;
    iomem_wdata = ~old;
    @(posedge ck); #2;
    rst = 1'b1;
    #1;
    n_tests++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL rstbusy_ready got %b exp 0", iomem_ready); end
    n_tests++; if (eng_data !== 32'h0) begin n_fail++; $display("FAIL rstbusy_eng_async got %h exp 0", eng_data); end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(posedge ck); #1;
    rst = 1'b0;
    ref_run = 0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge ck); #1;
      if (iomem_ready) pulses++;
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL rstbusy_pulses got %0d exp 0", pulses); end
    n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL rstbusy_run got %b exp 0", run); end
    eng_addr = AB'(w);
    @(posedge ck); #1;
    n_tests++; if (eng_data !== old) begin n_fail++; $display("FAIL rstbusy_word got %h exp %h", eng_data, old); end
    // run cleared asynchronously, without waiting for a clock edge.
    bus_xfer(32'h6200_0000, 4'hF, 32'h1);
    #2 rst = 1'b1;
    #1;
    ref_run = 0;
    n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL rst_async_run got %b exp 0", run); end
    @(posedge ck); #1;
    rst = 1'b0;
    @(posedge ck); #1;
  endtask

  task automatic test_alias();
    logic [31:0] d;
    logic [31:0] r;
    logic [31:0] a;
    d = $urandom();
    bus_xfer(32'h6000_0400, 4'hF, d);
    eng_addr = '0;
    @(posedge ck); #1;
    n_tests++; if (eng_data !== d) begin n_fail++; $display("FAIL alias_0400 got %h exp %h", eng_data, d); end
    for (int i = 0; i < 6; i++) begin
      r = $urandom();
      a = {8'h60, r[23:0]};
      bus_xfer(a, 4'hF, $urandom());
      eng_addr = a[AB+1:2];
      @(posedge ck); #1;
      n_tests++; if (eng_data !== ref_mem[int'(a[AB+1:2])]) begin n_fail++; $display("FAIL alias_rand a=%h got %h exp %h", a, eng_data, ref_mem[int'(a[AB+1:2])]); end
    end
  endtask

  task automatic test_eng_collision();
    int          w;
    logic [31:0] old;
    w = $urandom_range(0, DEPTH-1);
    old = ref_mem[w];
    eng_addr = AB'(w);
    bus_xfer(32'h6000_0000 | (32'(w) << 2), 4'hF, ~old);
    n_tests++; if (last_eng_ack !== old) begin n_fail++; $display("FAIL collide_old got %h exp %h", last_eng_ack, old); end
    n_tests++; if (eng_data !== ~old) begin n_fail++; $display("FAIL collide_new got %h exp %h", eng_data, ~old); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic [3:0]  s;
    int          kind;
    int          w;
    for (int i = 0; i < 250; i++) begin
      r = $urandom();
      kind = $urandom_range(0, 9);
      a = (kind < 8) ? {8'h60, r[23:0]} : {8'h62, r[23:0]};
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom());
      d = $urandom();
      exp = model_read(a);
      bus_xfer(a, s, d);
      n_tests++; if (last_lat != 2) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d exp 2", i, last_lat); end
      n_tests++; if (last_ready_after !== 1'b0 || last_rdata_after !== 32'h0 || last_leak !== 1'b0) begin
        n_fail++; $display("FAIL rand_idle_bus[%0d] got ready=%b rdata=%h leak=%b exp 0", i, last_ready_after, last_rdata_after, last_leak);
      end
      if (s == 4'h0) begin
        n_tests++; if (last_rdata !== exp) begin n_fail++; $display("FAIL rand_rdata[%0d] a=%h got %h exp %h", i, a, last_rdata, exp); end
      end
      n_tests++; if (run !== ref_run) begin n_fail++; $display("FAIL rand_run[%0d] got %b exp %b", i, run, ref_run); end
      w = $urandom_range(0, DEPTH-1);
      eng_addr = AB'(w);
      @(posedge ck); #1;
      n_tests++; if (eng_data !== ref_mem[w]) begin n_fail++; $display("FAIL rand_eng[%0d] w=%0d got %h exp %h", i, w, eng_data, ref_mem[w]); end
    end
  endtask

  initial begin
    test_reset();
    test_init_ram();
    test_readback();
    test_ctrl_run();
    test_byte_lanes();
    test_unselected();
    test_reset_mid_busy();
    test_alias();
    test_eng_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iomem_prog_ram.md
IOMEM_PROG_RAM -- requirements
Module: iomem_prog_ram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, program RAM word-address width (256 x 32).
REQ-002 SHALL have parameter PROG_REGION, default 8'h60, iomem_addr[31:24] value selecting the program RAM.
REQ-003 SHALL have parameter CTRL_REGION, default 8'h62, iomem_addr[31:24] value selecting the control register.
REQ-004 SHALL have port ck, input, 1: the only clock, all state on posedge ck.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port iomem_valid, input, 1: initiator request.
REQ-007 SHALL have port iomem_ready, output, 1: responder completion pulse.
REQ-008 SHALL have port iomem_wstrb, input, 4: byte-lane write enables; 0 means read.
REQ-009 SHALL have port iomem_addr, input, 32: byte address.
REQ-010 SHALL have port iomem_wdata, input, 32: write data.
REQ-011 SHALL have port iomem_rdata, output, 32: read data, valid while iomem_ready=1.
REQ-012 SHALL have port eng_addr, input, ADDR_BITS: engine-side program fetch address.
REQ-013 SHALL have port eng_data, output, 32: fetched opcode, one-cycle latency.
REQ-014 SHALL have port run, output, 1: ctrl bit0, engine run enable.

Function
REQ-015 SHALL respond only when iomem_valid=1 and iomem_addr[31:24] equals PROG_REGION or CTRL_REGION; other addresses leave iomem_ready=0 and iomem_rdata=0.
REQ-016 SHALL use FSM IDLE -> BUSY -> ACK -> IDLE; IDLE leaves on a selected valid request, BUSY lasts one cycle, ACK drives iomem_ready=1 for exactly one cycle.
REQ-017 SHALL produce iomem_ready two cycles after the cycle in which a selected iomem_valid is first sampled.
REQ-018 SHALL latch address, wstrb and wdata in IDLE; later bus changes do not affect the transaction.
REQ-019 SHALL require the initiator to drop iomem_valid on the edge where iomem_ready is seen; FSM returns to IDLE regardless.
REQ-020 SHALL index program RAM with iomem_addr[ADDR_BITS+1:2]; higher bits within the region alias (wrap).
REQ-021 SHALL write program RAM per byte lane: wstrb[n] enables bits 8n+7:8n.
REQ-022 SHALL ignore program RAM writes while run=1, but still complete the handshake.
REQ-023 SHALL write ctrl register bit0 from wdata[0] when wstrb[0]=1; other bits read as 0.
REQ-024 SHALL return ctrl register {31'b0, run} on control-region reads.
REQ-025 SHALL give eng_data = RAM[eng_addr sampled previous edge]; same-address bus write and engine read in one cycle return old data.
REQ-026 SHALL drive iomem_rdata to 0 whenever iomem_ready=0.

Reset
REQ-027 SHALL on rst force state IDLE, iomem_ready=0, iomem_rdata=0, run=0, eng_data=0; RAM contents are not cleared.
REQ-028 SHALL abandon an in-flight transaction when rst asserts mid-operation; no partial write occurs after reset release.

Configuration
REQ-029 SHALL, with macro PROG_RAM_READBACK_EN defined, return program RAM data on program-region reads.
REQ-030 SHALL, without PROG_RAM_READBACK_EN, return 0 on program-region reads, still acknowledging them.

Structure
REQ-031 SHALL take region constants, ctrl bit index and FSM state enum from shared package iomem_pkg.
REQ-032 SHALL instantiate one sub-module dpram (one write/read bus port, one read-only engine port, byte-enable write).

Verification
REQ-033 Write 0x60000000 <- 0x84212000, read back -> iomem_rdata=0x84212000 with ready two cycles after valid (READBACK_EN).
REQ-034 Write 0x62000000 <- 1, then write 0x60000004 <- 0xfe000000 -> run=1, eng_addr=1 yields old word, not 0xfe000000.
REQ-035 wstrb=4'b0011 write 0x0000abcd over 0xffffffff at 0x60000008 -> stored 0xffffabcd.
REQ-036 Access 0x64000000 -> iomem_ready stays 0 for 10 cycles, rdata=0.
REQ-037 Assert rst during BUSY of a write -> ready never pulses, RAM word unchanged, run=0.
REQ-038 Write 0x60000400 (ADDR_BITS=8) -> aliases word 0; eng_addr=0 returns written data next cycle.
